// File: rtl/cmd_credit_gate_if.sv
// Command stream interface for cmd_credit_gate: AXI-Stream style tdata/tvalid/tready.
// master drives tdata/tvalid, slave drives tready.
interface cmd_credit_gate_if #(
  parameter int DW = 128
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/cmd_credit_gate.sv
// Read-credit gate between host command stream and command FIFO; admits a command only when
// the read-data FIFO can absorb all its beats. Optional watchdog via macro CMD_CREDIT_WDOG_EN.
module cmd_credit_gate #(
  parameter int CREDITS     = 16,
  parameter int SLOTS       = 4,
  parameter int RD_MASK_LSB = 0,
  parameter int CNT_W       = 5,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  cmd_credit_gate_if.slave    s_cmd,
  cmd_credit_gate_if.master   m_cmd,
  input  logic                rdata_beat,
  input  logic                flush,
  output logic [CNT_W-1:0]    outstanding,
  output logic                stalled,
  output logic                err
);
  localparam int N_W = $clog2(SLOTS + 1);

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  if (CREDITS < SLOTS) begin : g_chk_credits
    $error("cmd_credit_gate: CREDITS must be >= SLOTS");
  end
  if (WDOG_CYCLES < 1) begin : g_chk_wdog
    $error("cmd_credit_gate: WDOG_CYCLES must be >= 1");
  end

  function automatic logic [N_W-1:0] count_reads(input logic [SLOTS-1:0] mask);
    logic [N_W-1:0] c;
    c = {N_W{1'b0}};
    for (int i = 0; i < SLOTS; i++) begin
      c = c + N_W'(mask[i]);
    end
    return c;
  endfunction

  state_t              state_r, state_s;
  logic [127:0]        data_r;
  logic [CNT_W-1:0]    outstanding_r, outstanding_s;
  logic                err_r, err_s;
  logic [N_W-1:0]      n_s;
  logic [CNT_W-1:0]    n_cnt_s;
  logic [CNT_W:0]      avail_s;
  logic                space_s, fit_s, ready_s, accept_s, under_s, wdog_hit_s;

  // Read-slot count, credit availability and handshake decisions
  always_comb begin
    n_s      = count_reads(s_cmd.tdata[RD_MASK_LSB +: SLOTS]);
    n_cnt_s  = CNT_W'(n_s);
    avail_s  = (CNT_W+1)'(CREDITS) - {1'b0, outstanding_r};
    space_s  = (state_r == ST_EMPTY) | m_cmd.tready;
    fit_s    = ({1'b0, n_cnt_s} <= avail_s);
    ready_s  = space_s & fit_s;
    accept_s = s_cmd.tvalid & ready_s;
    under_s  = rdata_beat & (outstanding_r == {CNT_W{1'b0}});
  end

  // Output stage next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) state_s = ST_FULL;
        else          state_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (accept_s)          state_s = ST_FULL;
        else if (m_cmd.tready) state_s = ST_EMPTY;
        else                   state_s = ST_FULL;
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // Credit accounting; a flush discards any same-cycle beat
  always_comb begin
    outstanding_s = outstanding_r;
    err_s         = err_r;
    if (flush) begin
      err_s = 1'b0;
      if (accept_s) outstanding_s = n_cnt_s;
      else          outstanding_s = {CNT_W{1'b0}};
    end else begin
      if (under_s | wdog_hit_s) err_s = 1'b1;
      else                      err_s = err_r;
      if (accept_s) outstanding_s = outstanding_s + n_cnt_s;
      else          outstanding_s = outstanding_s;
      if (rdata_beat && !under_s) outstanding_s = outstanding_s - CNT_W'(1);
      else                        outstanding_s = outstanding_s;
    end
  end

  // State, held command and accounting registers
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r       <= ST_EMPTY;
      data_r        <= 128'd0;
      outstanding_r <= {CNT_W{1'b0}};
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      outstanding_r <= outstanding_s;
      err_r         <= err_s;
      if (accept_s) data_r <= s_cmd.tdata;
      else          data_r <= data_r;
    end
  end

`ifdef CMD_CREDIT_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt_r;
  logic            wdog_run_s;

  // Watchdog runs only while reads are owed and none are returning
  always_comb begin
    wdog_run_s = (outstanding_r != {CNT_W{1'b0}}) & ~rdata_beat & ~flush;
    wdog_hit_s = wdog_run_s & (wdog_cnt_r == WD_W'(WDOG_CYCLES - 1));
  end

  // Watchdog counter
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wdog_cnt_r <= {WD_W{1'b0}};
    end else if (!wdog_run_s || wdog_hit_s) begin
      wdog_cnt_r <= {WD_W{1'b0}};
    end else begin
      wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
    end
  end
`else
  assign wdog_hit_s = 1'b0;
`endif

  assign s_cmd.tready = ready_s;
  assign stalled      = s_cmd.tvalid & space_s & ~fit_s;
  assign m_cmd.tvalid = (state_r == ST_FULL);
  assign m_cmd.tdata  = data_r;
  assign outstanding  = outstanding_r;
  assign err          = err_r;
endmodule

// File: tb/tb_cmd_credit_gate.sv
// Randomized self-checking bench for cmd_credit_gate against a credit-pool reference model.
module tb_cmd_credit_gate;
  localparam int CREDITS = 16;

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn = 1'b0;
  logic       rdata_beat = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] outstanding;
  logic       stalled;
  logic       err;

  cmd_credit_gate_if s_if ();
  cmd_credit_gate_if m_if ();

  cmd_credit_gate dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .s_cmd       (s_if),
    .m_cmd       (m_if),
    .rdata_beat  (rdata_beat),
    .flush       (flush),
    .outstanding (outstanding),
    .stalled     (stalled),
    .err         (err)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: held command slot plus an integer credit pool
  bit           mdl_valid;
  logic [127:0] mdl_data;
  int           mdl_out;
  bit           mdl_err;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [3:0] m);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[3:0] = m;
    return r;
  endfunction

  task automatic mdl_reset();
    mdl_valid = 1'b0;
    mdl_data  = 128'd0;
    mdl_out   = 0;
    mdl_err   = 1'b0;
  endtask

  // drive one cycle, compare at negedge, advance the model to the next edge
  task automatic step(input bit v, input logic [127:0] d, input bit mr, input bit beat, input bit fl);
    int  n, avail;
    bit  exp_ready, exp_stall, acc;
    s_if.tvalid = v;
    s_if.tdata  = d;
    m_if.tready = mr;
    rdata_beat  = beat;
    flush       = fl;
    @(negedge axi_aclk);
    n         = $countones(d[3:0]);
    avail     = CREDITS - mdl_out;
    exp_ready = (!mdl_valid || mr) && (n <= avail);
    exp_stall = v && (!mdl_valid || mr) && (n > avail);
    acc       = v && exp_ready;
    check_val("s_tready", s_if.tready, exp_ready);
    check_val("stalled", stalled, exp_stall);
    check_val("m_tvalid", m_if.tvalid, mdl_valid);
    check_val("m_tdata", m_if.tdata, mdl_data);
    check_val("outstanding", outstanding, mdl_out);
    check_val("err", err, mdl_err);
    if (acc) begin
      mdl_valid = 1'b1;
      mdl_data  = d;
    end else if (mr) begin
      mdl_valid = 1'b0;
    end
    if (fl) begin
      mdl_out = acc ? n : 0;
      mdl_err = 1'b0;
    end else if (beat && mdl_out == 0) begin
      mdl_err = 1'b1;
      mdl_out = acc ? n : 0;
    end else begin
      mdl_out = mdl_out + (acc ? n : 0) - (beat ? 1 : 0);
    end
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 128'd0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [127:0] held;

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 128'd0;
    m_if.tready = 1'b1;
    mdl_reset();
    #12;
    check_val("rst_m_tvalid", m_if.tvalid, 1'b0);
    check_val("rst_m_tdata", m_if.tdata, 128'd0);
    check_val("rst_outstanding", outstanding, 5'd0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_s_tready", s_if.tready, 1'b1);
    @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;

    // first 4-read command, latency 1
    held = mk(4'hF);
    step(1'b1, held, 1'b1, 1'b0, 1'b0);
    check_val("lat1_tdata", m_if.tdata, held);
    check_val("lat1_out", outstanding, 5'd4);

    // fill credits to the limit, then a 1-read command stalls
    for (int i = 0; i < 3; i++) step(1'b1, mk(4'hF), 1'b1, 1'b0, 1'b0);
    check_val("full_out", outstanding, 5'd16);
    held = mk(4'h2);
    step(1'b1, held, 1'b1, 1'b0, 1'b0);
    check_val("stall_flag", stalled, 1'b1);
    check_val("stall_ready", s_if.tready, 1'b0);
    step(1'b1, held, 1'b1, 1'b1, 1'b0);
    step(1'b1, held, 1'b1, 1'b0, 1'b0);
    check_val("unstall_out", outstanding, 5'd16);
    check_val("unstall_data", m_if.tdata, held);

    // zero-read command passes at full credit use
    held = mk(4'h0);
    step(1'b1, held, 1'b1, 1'b0, 1'b0);
    check_val("zero_out", outstanding, 5'd16);
    check_val("zero_data", m_if.tdata, held);

    // outstanding=5, then same-cycle 2-read accept and beat
    step(1'b0, 128'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(4'hF), 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(4'h8), 1'b1, 1'b0, 1'b0);
    check_val("five_out", outstanding, 5'd5);
    held = mk(4'h5);
    step(1'b1, held, 1'b1, 1'b1, 1'b0);
    check_val("acc_beat_out", outstanding, 5'd6);
    step(1'b1, mk(4'h1), 1'b0, 1'b0, 1'b0);
    check_val("hold_data", m_if.tdata, held);
    check_val("hold_ready", s_if.tready, 1'b0);

    // underflow and flush
    step(1'b0, 128'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 128'd0, 1'b1, 1'b1, 1'b0);
    check_val("under_err", err, 1'b1);
    check_val("under_out", outstanding, 5'd0);
    step(1'b0, 128'd0, 1'b1, 1'b0, 1'b1);
    check_val("flush_err", err, 1'b0);

`ifndef CMD_CREDIT_WDOG_EN
    step(1'b1, mk(4'h1), 1'b1, 1'b0, 1'b0);
    idle(200);
    check_val("no_wdog_err", err, 1'b0);
    check_val("no_wdog_out", outstanding, 5'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom},
           ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 64) == 0);
    end

    // asynchronous reset mid-operation
    step(1'b1, mk(4'h3), 1'b0, 1'b0, 1'b0);
    axi_aresetn = 1'b0;
    #2;
    mdl_reset();
    check_val("mid_rst_tvalid", m_if.tvalid, 1'b0);
    check_val("mid_rst_tdata", m_if.tdata, 128'd0);
    check_val("mid_rst_out", outstanding, 5'd0);
    check_val("mid_rst_err", err, 1'b0);
    @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 2) != 0, {$urandom, $urandom, $urandom, $urandom},
           ($urandom % 3) != 0, ($urandom % 2) == 0, ($urandom % 100) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end
endmodule
